// File: rtl/serial_subtract_if.sv
// Start/busy/done handshake bundle between a controller and serial_subtract.
// Signals: start, a, b, borrowIn (request); busy, done, diff, borrowOut (reply).
interface serial_subtract_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrowIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrowOut;

  modport master (
    output start,
    output a,
    output b,
    output borrowIn,
    input  busy,
    input  done,
    input  diff,
    input  borrowOut
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  borrowIn,
    output busy,
    output done,
    output diff,
    output borrowOut
  );
endinterface

// File: rtl/serial_subtract.sv
// Bit-serial subtracter: one bit pair per clock, LSB first, borrow via a flop.
// Ports: clk, rst_n (async active-low), bus (slave: start/a/b/borrowIn in,
// busy/done/diff/borrowOut out). Result = (a - b - borrowIn) mod 2^WIDTH.
module serial_subtract #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtract_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bo;
  logic             r_busy;
  logic             r_done;

  logic             w_start;
  logic             w_last;
  logic             w_d;
  logic             w_nb;

  // Single-bit full subtracter on the current LSBs.
  assign w_d  = r_a[0] ^ r_b[0] ^ r_br;
  assign w_nb = (~r_a[0] & r_b[0])
              | (~(r_a[0] ^ r_b[0]) & r_br);

  assign w_start = (r_state == S_IDLE) && bus.start;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_d    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bo   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_start) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_br  <= bus.borrowIn;
        r_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_a   <= {1'b0, r_a[WIDTH-1:1]};
        r_b   <= {1'b0, r_b[WIDTH-1:1]};
        r_d   <= {w_d, r_d[WIDTH-1:1]};
        r_br  <= w_nb;
        r_cnt <= r_cnt + 1'b1;
        // Result registers only move on the edge entering DONE.
        if (w_last) begin
          r_diff <= {w_d, r_d[WIDTH-1:1]};
          r_bo   <= w_nb;
        end
      end
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.diff      = r_diff;
  assign bus.borrowOut = r_bo;

endmodule
